// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer.
// Holds operand/result widths, opcode encodings, the sequencer state enum
// and the latched command payload.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RSP_W  = 2 * DATA_W;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NOT = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } seq_state_t;

    // Command as latched on acceptance.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    // Opcodes above MUL have no meaning and are answered with an error.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return op > OP_MUL;
    endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU.
// Ports:
//   A, B      operands
//   ALU_Sel   operation (ADD, SUB, AND, OR, NOT A)
//   ALU_Out   result, modulo 2^8
//   CarryOut  carry out of ADD, 0 for every other operation
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   ALU_Sel,
    output logic [DATA_W-1:0] ALU_Out,
    output logic              CarryOut
);

    logic [DATA_W:0] sum;

    // Operation decode; unused encodings yield zero.
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        ALU_Out  = '0;
        CarryOut = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                ALU_Out  = sum[DATA_W-1:0];
                CarryOut = sum[DATA_W];
            end
            OP_SUB:  ALU_Out = A - B;
            OP_AND:  ALU_Out = A & B;
            OP_OR:   ALU_Out = A | B;
            OP_NOT:  ALU_Out = ~A;
            default: ALU_Out = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven controller around the 8-bit ALU. Runs single-cycle ALU ops
// and a MUL_ITER-cycle shift-add multiply, returning a registered 16-bit
// result over a valid/ready response channel.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b         opcode, operand A (multiplicand), operand B
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_carry, rsp_err result, ADD carry, illegal-opcode flag
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned MUL_ITER = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RSP_W-1:0]  rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err
);

    localparam int unsigned      CNT_W    = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    seq_state_t        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [RSP_W-1:0]  prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [OP_W-1:0]   alu_sel;
    logic              alu_carry;
    logic [RSP_W-1:0]  prod_step;

    // ALU operand select: latched command, or the multiply accumulator.
    always_comb begin
        alu_a   = cmd_q.a;
        alu_b   = cmd_q.b;
        alu_sel = cmd_q.op;
        if (state_q == MUL) begin
            alu_a   = prod_q[RSP_W-1:DATA_W];
            alu_b   = prod_q[0] ? cmd_q.a : '0;
            alu_sel = OP_ADD;
        end
    end

    alu u_alu (
        .A        (alu_a),
        .B        (alu_b),
        .ALU_Sel  (alu_sel),
        .ALU_Out  (alu_out),
        .CarryOut (alu_carry)
    );

    // {carry, sum, low byte} shifted right by one. Bit 16 of the 17-bit
    // product register is always zero after the shift, so only 16 bits are kept.
    assign prod_step = {alu_carry, alu_out, prod_q[DATA_W-1:1]};

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d.op = cmd_op;
                    cmd_d.a  = cmd_a;
                    cmd_d.b  = cmd_b;
                    if (op_is_illegal(cmd_op)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_carry_d = 1'b0;
                    end else if (cmd_op == OP_MUL) begin
                        state_d = MUL;
                        prod_d  = RSP_W'(cmd_b);
                        cnt_d   = '0;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end

            EXEC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = RSP_W'(alu_out);
                rsp_carry_d = (cmd_q.op == OP_ADD) && alu_carry;
                rsp_err_d   = 1'b0;
            end

            MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = prod_step;
                    rsp_carry_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Ready decodes from registered state only; held low while in reset.
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: the driver pushes expected responses
// computed by an arithmetic reference model; a monitor pops and compares.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int unsigned MUL_ITER = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;

    alu_sequencer #(.MUL_ITER(MUL_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   outstanding = 0;
    bit   mon_en = 1'b0;
    bit   seen = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: results straight from the arithmetic meaning of each opcode.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ia = int'(a);
        int   ib = int'(b);
        e.data = 16'h0; e.carry = 1'b0; e.err = 1'b0; e.lat = 2; e.acc = 0;
        case (op)
            3'd0: begin e.data = 16'((ia + ib) % 256); e.carry = (ia + ib) >= 256; end
            3'd1: e.data = 16'((256 + ia - ib) % 256);
            3'd2: e.data = 16'(ia & ib);
            3'd3: e.data = 16'(ia | ib);
            3'd4: e.data = 16'(255 - ia);
            3'd5: begin e.data = 16'(ia * ib); e.lat = 1 + MUL_ITER; end
            default: begin e.err = 1'b1; e.lat = 1; end
        endcase
        return e;
    endfunction

    // Issue one command; returns at the acceptance edge + #1.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output int acc);
        exp_t e;
        int   waited = 0;
        bit   got = 1'b0;
        acc = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!got && waited < 100) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; acc = cyc; end
            else waited++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL cmd_accept: timeout waiting for cmd_ready, want 1");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e = model(op, a, b);
        e.acc = acc;
        sb.push_back(e);
        outstanding++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (outstanding > 0 && n < 500) begin @(posedge clk); n++; end
        #1;
        if (outstanding > 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout: outstanding=%0d want 0", outstanding);
        end
    endtask

    // Monitor: compares each response, its latency, and its stability while held.
    always @(negedge clk) begin
        if (mon_en) begin
            if (outstanding > 0) check("cmd_ready_busy", 32'(cmd_ready), 32'(0));
            if (rsp_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rsp: data=0x%0h want no response", rsp_data);
                    end else begin
                        cur = sb.pop_front();
                        seen = 1'b1;
                        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end
                if (seen) begin
                    check("rsp_data", 32'(rsp_data), 32'(cur.data));
                    check("rsp_carry", 32'(rsp_carry), 32'(cur.carry));
                    check("rsp_err", 32'(rsp_err), 32'(cur.err));
                    if (rsp_ready) begin
                        seen = 1'b0;
                        outstanding--;
                    end
                end
            end
        end
    end

    // Random backpressure on the response channel.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) rsp_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3;
        logic [2:0] rop;
        logic [7:0] ra, rb;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        check("rst_rsp_carry", 32'(rsp_carry), 32'(0));
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        mon_en = 1'b1;

        // ADD with carry out.
        issue(3'd0, 8'd200, 8'd100, a0);
        wait_idle();

        // Back-to-back ALU ops with rsp_ready high: 3-cycle spacing.
        issue(3'd1, 8'd5, 8'd10, a1);
        issue(3'd4, 8'h0F, 8'h00, a2);
        issue(3'd0, 8'd3, 8'd4, a3);
        check("spacing_1", 32'(a2 - a1), 32'(3));
        check("spacing_2", 32'(a3 - a2), 32'(3));
        wait_idle();

        // Multiplies, including the largest product.
        issue(3'd5, 8'd255, 8'd255, a0);
        issue(3'd5, 8'd0, 8'h77, a0);
        issue(3'd5, 8'd13, 8'd11, a0);
        wait_idle();

        // Illegal opcode, then a normal command.
        issue(3'd7, 8'h12, 8'h34, a0);
        issue(3'd6, 8'h01, 8'h02, a0);
        issue(3'd0, 8'd9, 8'd6, a0);
        wait_idle();

        // Backpressure: result held, a competing command is ignored.
        rsp_ready = 1'b0;
        issue(3'd0, 8'd1, 8'd1, a0);
        cmd_op = 3'd0; cmd_a = 8'd9; cmd_b = 8'd9; cmd_valid = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a multiply aborts it silently.
        issue(3'd5, 8'd200, 8'd3, a0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        outstanding = 0;
        seen = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check("abort_rsp_data", 32'(rsp_data), 32'(0));
        check("abort_rsp_carry", 32'(rsp_carry), 32'(0));
        check("abort_rsp_err", 32'(rsp_err), 32'(0));
        check("abort_cmd_ready", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        mon_en = 1'b1;
        issue(3'd0, 8'd7, 8'd8, a0);
        wait_idle();

        // Random commands with random response backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
            rb  = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
            issue(rop, ra, rb, a0);
        end
        wait_idle();
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
